// File: rtl/inj_pkg.sv
// Shared types and constants for the instruction injector.
// FSM state encoding, the bubble (stall) instruction encoding and the
// opcode field location used to recognise it.
package inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } inj_state_t;

    localparam int          OPCODE_MSB = 6;
    localparam int          OPCODE_LSB = 0;
    localparam logic [6:0]  NOP_OPCODE = 7'h7F;
    localparam logic [31:0] NOP_INST   = 32'h0000007F;

    // True when the instruction carries the stall/bubble opcode.
    function automatic logic is_bubble(input logic [31:0] inst);
        return (inst[OPCODE_MSB:OPCODE_LSB] == NOP_OPCODE);
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// Synchronous FIFO buffering instructions between the source and the core
// fetch port. Head is read straight from storage (no bypass), so a word
// pushed in cycle N is visible at the head in cycle N+1.
module inj_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/inst_injector.sv
// Instruction injector: buffers a free instruction stream, turns the
// stall opcode into bubbles, feeds the core fetch port with back-pressure
// and, after MAX_INSTS real instructions, drains the pipeline before
// raising a sticky done.
// Optional build macro INJ_ASSERT_EN embeds protocol assertions and a
// cover point on reaching DONE.
module inst_injector
    import inj_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INSTS    = 8,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        start,
    input  logic [31:0] src_inst,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] fetch_inst,
    output logic        fetch_valid,
    input  logic        fetch_stall,
    output logic [7:0]  inst_count,
    output logic        drain_active,
    output logic        done
);

    localparam logic [7:0] MAX_C       = 8'(MAX_INSTS);
    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);

    inj_state_t  state_r;
    logic [7:0]  inst_count_r;
    logic [7:0]  drain_cnt_r;

    logic        push_s;
    logic        pop_s;
    logic        accept_s;
    logic        full_s;
    logic        empty_s;
    logic [31:0] head_s;

    assign src_ready = (state_r == ST_INJECT) && !full_s && (inst_count_r < MAX_C);
    assign accept_s  = src_valid && src_ready;
    assign push_s    = accept_s && !is_bubble(src_inst);

    assign fetch_valid = !empty_s && ((state_r == ST_INJECT) || (state_r == ST_DRAIN));
    assign pop_s       = fetch_valid && !fetch_stall;

    assign inst_count   = inst_count_r;
    assign drain_active = (state_r == ST_DRAIN);
    assign done         = (state_r == ST_DONE);

    // Present the buffered head only when it is a real instruction; otherwise a bubble.
    always_comb begin
        fetch_inst = NOP_INST;
        if (fetch_valid) begin
            fetch_inst = head_s;
        end else begin
            fetch_inst = NOP_INST;
        end
    end

    inj_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_x (reset_x),
        .push    (push_s),
        .pop     (pop_s),
        .din     (src_inst),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Sequencing FSM with the accepted-instruction and drain counters.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_r      <= ST_IDLE;
            inst_count_r <= 8'd0;
            drain_cnt_r  <= 8'd0;
        end else begin
            if (push_s) begin
                inst_count_r <= inst_count_r + 8'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    if (inst_count_r == MAX_C) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only uninterrupted empty cycles count toward completion.
                    if (!empty_s) begin
                        drain_cnt_r <= 8'd0;
                    end else if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INJ_ASSERT_EN
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_x)
        !(push_s && full_s));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_x)
        !(pop_s && empty_s));
    a_idle_done_invalid: assert property (@(posedge clk) disable iff (!reset_x)
        ((state_r == ST_IDLE) || (state_r == ST_DONE)) |-> !fetch_valid);
    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_x)
        (fetch_valid && fetch_stall) |=> $stable(fetch_inst));
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_x)
        inst_count_r <= MAX_C);
    a_done_empty: assert property (@(posedge clk) disable iff (!reset_x)
        done |-> empty_s);
    a_no_bubble_valid: assert property (@(posedge clk) disable iff (!reset_x)
        fetch_valid |-> (fetch_inst[OPCODE_MSB:OPCODE_LSB] != NOP_OPCODE));
    c_reach_done: cover property (@(posedge clk) disable iff (!reset_x)
        state_r == ST_DONE);
`endif

endmodule

// File: tb/tb_inst_injector.sv
// Directed bench for inst_injector: a vector table for the buffering /
// back-pressure / bubble behaviour plus hand sequences for drain timing,
// reset during drain and a MAX_INSTS=1 / DRAIN_CYCLES=1 instance.
module tb_inst_injector;

    localparam logic [31:0] NOP = 32'h0000007F;

    logic        clk;
    logic        reset_x;
    logic        start;
    logic [31:0] src_inst;
    logic        src_valid;
    logic        fetch_stall;

    logic        src_ready,   src_ready_b;
    logic [31:0] fetch_inst,  fetch_inst_b;
    logic        fetch_valid, fetch_valid_b;
    logic [7:0]  inst_count,  inst_count_b;
    logic        drain_active, drain_active_b;
    logic        done,        done_b;

    int n_pass;
    int n_total;

    inst_injector #(.FIFO_DEPTH(4), .MAX_INSTS(8), .DRAIN_CYCLES(32)) dut (
        .clk(clk), .reset_x(reset_x), .start(start),
        .src_inst(src_inst), .src_valid(src_valid), .src_ready(src_ready),
        .fetch_inst(fetch_inst), .fetch_valid(fetch_valid), .fetch_stall(fetch_stall),
        .inst_count(inst_count), .drain_active(drain_active), .done(done)
    );

    inst_injector #(.FIFO_DEPTH(4), .MAX_INSTS(1), .DRAIN_CYCLES(1)) dut_b (
        .clk(clk), .reset_x(reset_x), .start(start),
        .src_inst(src_inst), .src_valid(src_valid), .src_ready(src_ready_b),
        .fetch_inst(fetch_inst_b), .fetch_valid(fetch_valid_b), .fetch_stall(fetch_stall),
        .inst_count(inst_count_b), .drain_active(drain_active_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        sv;
        logic [31:0] si;
        logic        st;
        logic        rdy;
        logic        fv;
        logic [31:0] fi;
        logic [7:0]  cnt;
        logic        dra;
        logic        dn;
    } vec_t;

    vec_t        tbl [18];
    logic [31:0] ins [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_x     = 1'b0;
        start       = 1'b0;
        src_valid   = 1'b0;
        src_inst    = 32'h0;
        fetch_stall = 1'b0;
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " src_ready"},    {31'd0, src_ready},    32'd0);
        chk({tag, " fetch_valid"},  {31'd0, fetch_valid},  32'd0);
        chk({tag, " fetch_inst"},   fetch_inst,            NOP);
        chk({tag, " inst_count"},   {24'd0, inst_count},   32'd0);
        chk({tag, " drain_active"}, {31'd0, drain_active}, 32'd0);
        chk({tag, " done"},         {31'd0, done},         32'd0);
    endtask

    initial begin
        int n;
        n_pass      = 0;
        n_total     = 0;
        reset_x     = 1'b0;
        start       = 1'b0;
        src_valid   = 1'b0;
        src_inst    = 32'h0;
        fetch_stall = 1'b0;

        ins[0] = 32'h00100093; ins[1] = 32'h00200113;
        ins[2] = 32'h00300193; ins[3] = 32'h00400213;
        ins[4] = 32'h00500293; ins[5] = 32'h00600313;
        ins[6] = 32'h00700393; ins[7] = 32'h00800413;

        //            start sv    si      st  | rdy   fv    fi      cnt   dra   dn
        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, NOP,    8'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, ins[0], 1'b1, 1'b1, 1'b0, NOP,    8'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, NOP,    1'b1, 1'b1, 1'b1, ins[0], 8'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, ins[1], 1'b1, 1'b1, 1'b1, ins[0], 8'd1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, ins[2], 1'b1, 1'b1, 1'b1, ins[0], 8'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, ins[3], 1'b1, 1'b1, 1'b1, ins[0], 8'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, ins[4], 1'b1, 1'b0, 1'b1, ins[0], 8'd4, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, ins[4], 1'b0, 1'b0, 1'b1, ins[0], 8'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, ins[4], 1'b0, 1'b1, 1'b1, ins[1], 8'd4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, ins[2], 8'd5, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, ins[3], 8'd5, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, NOP,    1'b0, 1'b1, 1'b1, ins[4], 8'd5, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, NOP,    1'b0, 1'b1, 1'b0, NOP,    8'd5, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, ins[5], 1'b0, 1'b1, 1'b0, NOP,    8'd5, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, ins[6], 1'b0, 1'b1, 1'b1, ins[5], 8'd6, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, ins[7], 1'b0, 1'b1, 1'b1, ins[6], 8'd7, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, ins[0], 1'b1, 1'b0, 1'b1, ins[7], 8'd8, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, ins[7], 8'd8, 1'b1, 1'b0};

        // Reset, then idle with no start: everything stays at reset values.
        do_reset();
        chk_idle("reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", i));
        end

        // Table: stall fill to full, release in order, interleaved bubbles, drain entry.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d src_ready", i),    {31'd0, src_ready},    {31'd0, tbl[i].rdy});
            chk($sformatf("row%0d fetch_valid", i),  {31'd0, fetch_valid},  {31'd0, tbl[i].fv});
            chk($sformatf("row%0d fetch_inst", i),   fetch_inst,            tbl[i].fi);
            chk($sformatf("row%0d inst_count", i),   {24'd0, inst_count},   {24'd0, tbl[i].cnt});
            chk($sformatf("row%0d drain_active", i), {31'd0, drain_active}, {31'd0, tbl[i].dra});
            chk($sformatf("row%0d done", i),         {31'd0, done},         {31'd0, tbl[i].dn});
            start       = tbl[i].start;
            src_valid   = tbl[i].sv;
            src_inst    = tbl[i].si;
            fetch_stall = tbl[i].st;
        end
        // Last pop happened in row 17; count empty drain cycles until done.
        @(negedge clk);
        chk("tbl drain empty valid", {31'd0, fetch_valid}, 32'd0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tbl drain length", n, 32'd32);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tbl done sticky", {31'd0, done}, 32'd1);
        chk("tbl done no drain", {31'd0, drain_active}, 32'd0);

        // Eight identical ADDI back-to-back, no stall.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("addi%0d ready", i), {31'd0, src_ready}, 32'd1);
            chk($sformatf("addi%0d valid", i), {31'd0, fetch_valid}, (i == 0) ? 32'd0 : 32'd1);
            src_valid = 1'b1;
            src_inst  = 32'h00100093;
            @(negedge clk);
        end
        src_valid = 1'b0;
        chk("addi count", {24'd0, inst_count}, 32'd8);
        chk("addi ready at max", {31'd0, src_ready}, 32'd0);
        chk("addi last inst", fetch_inst, 32'h00100093);
        chk("addi drain not yet", {31'd0, drain_active}, 32'd0);
        @(negedge clk);
        chk("addi drain rises", {31'd0, drain_active}, 32'd1);
        chk("addi drain empty", {31'd0, fetch_valid}, 32'd0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("addi drain length", n, 32'd32);

        // Reset during DRAIN with two entries still queued.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_valid   = 1'b1;
            src_inst    = ins[i];
            fetch_stall = (i == 7);
            @(negedge clk);
        end
        src_valid = 1'b0;
        chk("rstdrain count", {24'd0, inst_count}, 32'd8);
        chk("rstdrain head", fetch_inst, ins[6]);
        @(negedge clk);
        chk("rstdrain in drain", {31'd0, drain_active}, 32'd1);
        chk("rstdrain queued", {31'd0, fetch_valid}, 32'd1);
        chk("rstdrain head held", fetch_inst, ins[6]);
        reset_x = 1'b0;
        @(negedge clk);
        reset_x     = 1'b1;
        fetch_stall = 1'b0;
        chk_idle("rstdrain after");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rstdrain restart ready", {31'd0, src_ready}, 32'd1);
        chk("rstdrain flushed", {31'd0, fetch_valid}, 32'd0);

        // MAX_INSTS=1, DRAIN_CYCLES=1 instance.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b ready", {31'd0, src_ready_b}, 32'd1);
        src_valid = 1'b1;
        src_inst  = ins[2];
        @(negedge clk);
        src_valid = 1'b0;
        chk("b count", {24'd0, inst_count_b}, 32'd1);
        chk("b ready at max", {31'd0, src_ready_b}, 32'd0);
        chk("b valid", {31'd0, fetch_valid_b}, 32'd1);
        chk("b inst", fetch_inst_b, ins[2]);
        chk("b drain not yet", {31'd0, drain_active_b}, 32'd0);
        @(negedge clk);
        chk("b drain", {31'd0, drain_active_b}, 32'd1);
        chk("b empty", {31'd0, fetch_valid_b}, 32'd0);
        chk("b not done", {31'd0, done_b}, 32'd0);
        @(negedge clk);
        chk("b done", {31'd0, done_b}, 32'd1);
        chk("b drain off", {31'd0, drain_active_b}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
